// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the MIPS multiply/divide unit controller:
// MDU opcodes, controller states and the busy-counter width.
package mdu_ctrl_pkg;

   localparam int MD_CNT_W = 4;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage request, D-stage hazard query and HI/LO result bundle between
// the pipeline (master) and the MDU controller (slave).
interface mdu_ctrl_if;

   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        md_use_d;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_req;

   modport master (
      output start, op, a, b, md_use_d,
      input  busy, hi, lo, stall_req
   );

   modport slave (
      input  start, op, a, b, md_use_d,
      output busy, hi, lo, stall_req
   );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU arithmetic: 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU
// plus a divide-by-zero flag so the controller can leave HI/LO untouched.
module mdu_arith
   import mdu_ctrl_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   output logic [63:0] result,
   output logic        divZero
);

   logic [63:0] aExt;
   logic [63:0] bExt;
   logic [63:0] product;
   logic        signedDiv;
   logic        aNeg;
   logic        bNeg;
   logic [31:0] aMag;
   logic [31:0] bMag;
   logic [31:0] bSafe;
   logic [31:0] quoMag;
   logic [31:0] remMag;
   logic [31:0] quo;
   logic [31:0] rem;

   // Division runs on magnitudes so the truncate-toward-zero quotient and
   // dividend-signed remainder fall out of the sign fix-up, INT_MIN/-1 included.
   always_comb begin
      aExt      = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
      bExt      = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
      product   = aExt * bExt;

      signedDiv = (op == MD_DIV);
      aNeg      = signedDiv & a[31];
      bNeg      = signedDiv & b[31];
      aMag      = aNeg ? (~a + 32'd1) : a;
      bMag      = bNeg ? (~b + 32'd1) : b;
      bSafe     = (bMag == 32'd0) ? 32'd1 : bMag;
      quoMag    = aMag / bSafe;
      remMag    = aMag % bSafe;
      quo       = (aNeg ^ bNeg) ? (~quoMag + 32'd1) : quoMag;
      rem       = aNeg ? (~remMag + 32'd1) : remMag;

      divZero   = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

      case (op)
         MD_MULT, MD_MULTU: result = product;
         MD_DIV, MD_DIVU:   result = {rem, quo};
         default:           result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: sequences multi-cycle MULT/DIV with a busy counter, owns
// HI/LO, and asks the hazard unit to stall dependent D-stage instructions.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input logic       clk,
   input logic       rst,
   mdu_ctrl_if.slave md
);

   localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

   md_state_e           state;
   md_state_e           stateNext;
   logic [MD_CNT_W-1:0] count;
   logic [MD_CNT_W-1:0] countNext;
   logic [31:0]         hiReg;
   logic [31:0]         hiNext;
   logic [31:0]         loReg;
   logic [31:0]         loNext;
   logic [63:0]         pending;
   logic [63:0]         pendingNext;
   logic                pendingWr;
   logic                pendingWrNext;
   logic [63:0]         arithResult;
   logic                divZero;

   mdu_arith arith (
      .a       (md.a),
      .b       (md.b),
      .op      (md.op),
      .result  (arithResult),
      .divZero (divZero)
   );

   // The result is computed and parked at issue; the busy period only models
   // the unit's latency, and a divide by zero simply never commits.
   always_comb begin
      stateNext     = state;
      countNext     = count;
      hiNext        = hiReg;
      loNext        = loReg;
      pendingNext   = pending;
      pendingWrNext = pendingWr;
      case (state)
         S_IDLE: begin
            if (md.start) begin
               case (md.op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     pendingNext   = arithResult;
                     pendingWrNext = ~divZero;
                     countNext     = (md.op == MD_DIV || md.op == MD_DIVU) ? DIV_LOAD : MULT_LOAD;
                     stateNext     = S_RUN;
                  end
                  MD_MTHI: hiNext = md.a;
                  MD_MTLO: loNext = md.a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            countNext = count - 1'b1;
            if (count == MD_CNT_W'(1)) begin
               stateNext = S_IDLE;
               if (pendingWr) begin
                  hiNext = pending[63:32];
                  loNext = pending[31:0];
               end
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         count     <= '0;
         hiReg     <= '0;
         loReg     <= '0;
         pending   <= '0;
         pendingWr <= 1'b0;
      end else begin
         state     <= stateNext;
         count     <= countNext;
         hiReg     <= hiNext;
         loReg     <= loNext;
         pending   <= pendingNext;
         pendingWr <= pendingWrNext;
      end
   end

   assign md.busy      = (state == S_RUN);
   assign md.hi        = hiReg;
   assign md.lo        = loReg;
   assign md.stall_req = md.md_use_d & (md.busy | (md.start & (md.op <= 3'd3)));

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the pipelined MIPS core; sits beside the E-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, sequences the multi-cycle operation with a busy counter, and owns the HI/LO registers.
- Raises a stall request to the hazard unit while any D-stage instruction that touches the MDU or HI/LO must wait.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
- start  in  1  E-stage MDU instruction valid this cycle
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  rt operand (divisor / multiplier)
- md_use_d  in  1  D-stage instruction is an MDU op or MFHI/MFLO
- busy  out  1  operation in progress (registered)
- hi  out  32  HI register
- lo  out  32  LO register
- stall_req  out  1  combinational: md_use_d & (busy | (start & op<=3))

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, busy=0, hi=0, lo=0, counter=0, pending result cleared. Takes priority over everything, including an operation in progress (that operation is discarded).
- FSM states:
  - IDLE
  - RUN
- IDLE, start=1, op in 0..3:
  - Latch the computed 64-bit result into a pending register.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each edge. At the edge where counter==1, hi/lo take the pending result, busy falls, state=IDLE.
- Latency: start sampled at edge k -> busy=1 in cycles k+1..k+N. New hi/lo are visible in the cycle following the last busy cycle (N = MULT_CYCLES or DIV_CYCLES).
- MTHI/MTLO with start=1 in IDLE: hi (resp. lo) <= a at the next edge; busy stays 0; the other register is unchanged.
- start=1 while busy=1 (any op): ignored, no state change. The hazard unit guarantees this never occurs; the bench flags it.
- op 6/7 with start=1: no effect.
- Arithmetic:
  - MULT: {hi,lo} = signed a * signed b, 64-bit.
  - MULTU: unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0, DIV or DIVU): the full busy period still elapses; hi and lo remain unchanged at completion.
- stall_req also covers the cycle in which start is asserted, so a back-to-back MDU instruction in D never issues during that cycle.
- Reading hi/lo while busy=1 returns the old values; the hazard unit stalls MFHI/MFLO via stall_req.

Decomposition:
- Shared package holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  - state encodings: S_IDLE, S_RUN
  - counter width constant MD_CNT_W=4
- One sub-module is natural: mdu_arith, purely combinational (a, b, op -> 64-bit result plus div-by-zero flag), so the arithmetic can be checked in isolation.
- FSM, counter and HI/LO registers stay in mdu_ctrl.

Test Plan:
- Reset then MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy exactly 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with DIVU a=7, b=2 -> lo=3, hi=1.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> busy never asserts; hi=0x12345678 and lo=0x9ABCDEF0 one edge after each start.
- Start DIV with b=0 after hi=0x11, lo=0x22 -> busy for 10 cycles; hi=0x11, lo=0x22 unchanged. Hold md_use_d=1 throughout -> stall_req=1 for the start cycle plus all 10 busy cycles, then 0.
- Start MULT, drive rst=0 on the 3rd busy cycle -> next cycle busy=0, hi=0, lo=0. A second start asserted while busy in a separate run is ignored: the result reflects the first operands only.
